audio_sfx_scheduler: RTL and testbench
======================================

Name: audio_sfx_scheduler

Overview:
- Shares the single square-wave tone datapath and the Audio_Controller output FIFO between looping lobby music and three one-shot sound effects (hit, miss, game-over).
- Sequences a note ROM holding one half-period delay per beat and arbitrates between requesters by fixed priority, with preemption.
- Drives left/right samples and write_audio_out to the Audio_Controller.
- Sits between game FSM and Audio_Controller; replaces per-track ad-hoc players.

Parameters:
BEAT_CYCLES, 2500000, CLOCK_50 cycles per note (beat)
ADDR_W, 10, note ROM address width
DELAY_W, 19, half-period delay width (cycles); 0 means rest
AMPLITUDE, 100000000, square-wave magnitude (signed 32-bit)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
lobby_en  in  1  level; lobby music loops while high
sfx_req  in  3  one-cycle request pulses; bit0 game-over (highest), bit1 miss, bit2 hit
rom_addr  out  ADDR_W  note ROM address
rom_q  in  DELAY_W  note ROM data, valid 1 cycle after rom_addr
audio_out_allowed  in  1  Audio_Controller FIFO has space
write_audio_out  out  1  sample write strobe
left_channel_audio_out  out  32  sample
right_channel_audio_out  out  32  same sample as left
active_track  out  2  0 lobby, 1 game-over, 2 miss, 3 hit (valid when busy)
busy  out  1  a track is playing
sfx_done  out  1  one-cycle pulse when a one-shot finishes naturally

Behaviour:
- Reset (async, reset=1): state IDLE; all outputs 0; pending, counters, snd cleared.
- Track table (package): base address and length in beats for each of the 4 tracks; lobby loops, SFX play once.
- pending[2:0]: bit set on sfx_req pulse, cleared when that track is granted. Set has priority over clear in the same cycle (re-request during grant replays once).
- Priority: game-over > miss > hit > lobby.
- States:
  - IDLE: if any pending -> FETCH highest pending; else if lobby_en -> FETCH lobby at index 0.
  - FETCH (1 cycle): rom_addr = base+index already driven; next cycle latch rom_q into half_period; -> PLAY; beat_cnt=0, delay_cnt=0, snd=0.
  - PLAY: beat_cnt++ each cycle.
    - At BEAT_CYCLES-1, index++ and -> FETCH.
    - If index was len-1:
      - SFX: pulse sfx_done; -> FETCH of next highest pending; else lobby at index 0 if lobby_en; else IDLE.
      - Lobby: index wraps to 0, stays lobby.
- Preemption: pending bit of higher priority than active_track -> FETCH of that track at index 0 next cycle; the preempted SFX is dropped (no sfx_done); preempted lobby restarts at index 0 later.
- lobby_en low while lobby playing -> IDLE next cycle. SFX ignore lobby_en.
- Tone, PLAY only: delay_cnt increments each cycle. When delay_cnt == half_period-1: snd toggles, delay_cnt=0.
  - half_period==0 is a rest: snd held 0, sample 0.
- Sample: PLAY and half_period!=0 -> snd ? +AMPLITUDE : -AMPLITUDE (two's complement 32-bit); otherwise 0.
- write_audio_out = audio_out_allowed & (state==PLAY). No backpressure on sequencing; dropped samples are acceptable.
- busy = state != IDLE. active_track updates on entering FETCH.
- Counters: beat_cnt 23 bits, delay_cnt DELAY_W bits; no overflow since compares are bounded.

Decomposition:
- Package audio_sfx_pkg:
  - track id localparams (TRK_LOBBY=0, TRK_OVER=1, TRK_MISS=2, TRK_HIT=3)
  - per-track base/length constants
  - state encoding (IDLE, FETCH, PLAY)
- One sub-module, square_tone_gen: delay_cnt/snd toggle and sample mux; inputs half_period and run; output sample.
- Scheduler FSM, pending register and arbiter stay in the top module.

Test Plan:
- BEAT_CYCLES=8; lobby_en=1 with lobby len 4, rom_q=3 -> addresses base..base+3 each held 9 cycles (FETCH+8 PLAY), then wrap to base; snd toggles every 3 cycles; sample ±100000000.
- Lobby playing, sfx_req[2] pulse -> next cycle active_track=3 at hit base. After hit len beats, sfx_done pulses once, then lobby resumes at index 0.
- Hit playing, sfx_req[0] pulse -> game-over preempts next cycle; no sfx_done for hit; game-over completes with sfx_done.
- sfx_req[1] and sfx_req[2] same cycle from IDLE, lobby_en=0 -> miss plays, then hit, then IDLE, busy=0; two sfx_done pulses.
- rom_q=0 note -> samples 0 for that beat while write_audio_out follows audio_out_allowed; audio_out_allowed=0 -> write_audio_out=0, sequencing continues.
- reset asserted mid-PLAY (async, between clock edges) -> outputs 0 immediately, pending cleared; after release with lobby_en=1 -> lobby restarts at index 0.

Source files
------------

// File: rtl/audio_sfx_pkg.sv
// Shared constants for the lobby/SFX audio scheduler:
// track ids, note ROM layout and FSM encoding.
package audio_sfx_pkg;

  localparam logic [1:0] TRK_LOBBY = 2'd0;
  localparam logic [1:0] TRK_OVER  = 2'd1;
  localparam logic [1:0] TRK_MISS  = 2'd2;
  localparam logic [1:0] TRK_HIT   = 2'd3;

  localparam int BEAT_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2
  } state_t;

  function automatic int trk_base(logic [1:0] t);
    case (t)
      TRK_OVER: return 64;
      TRK_MISS: return 128;
      TRK_HIT:  return 192;
      default:  return 0;
    endcase
  endfunction

  function automatic int trk_len(logic [1:0] t);
    case (t)
      TRK_OVER: return 3;
      TRK_MISS: return 2;
      TRK_HIT:  return 2;
      default:  return 4;
    endcase
  endfunction

  // pending[] bit owned by a track; lobby has none
  function automatic logic [2:0] trk_mask(logic [1:0] t);
    case (t)
      TRK_OVER: return 3'b001;
      TRK_MISS: return 3'b010;
      TRK_HIT:  return 3'b100;
      default:  return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/audio_sfx_scheduler_if.sv
// Note ROM and Audio_Controller FIFO signals of the scheduler.
// master = scheduler, slave = ROM / Audio_Controller side.
interface audio_sfx_scheduler_if #(
  parameter int ADDR_W  = 10,
  parameter int DELAY_W = 19
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [DELAY_W-1:0] rom_q;
  logic               audio_out_allowed;
  logic               write_audio_out;
  logic signed [31:0] left_channel_audio_out;
  logic signed [31:0] right_channel_audio_out;

  modport master (
    output rom_addr,
    input  rom_q,
    input  audio_out_allowed,
    output write_audio_out,
    output left_channel_audio_out,
    output right_channel_audio_out
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    output audio_out_allowed,
    input  write_audio_out,
    input  left_channel_audio_out,
    input  right_channel_audio_out
  );
endinterface

// File: rtl/square_tone_gen.sv
// Square-wave tone: toggles every half_period cycles while run,
// zero half_period is a rest.
module square_tone_gen #(
  parameter int DELAY_W   = 19,
  parameter int AMPLITUDE = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DELAY_W-1:0] half_period,
  input  logic               run,
  output logic signed [31:0] sample
);

  localparam logic signed [31:0] AMP  = 32'(AMPLITUDE);
  localparam logic signed [31:0] NAMP = -AMP;
  localparam logic [DELAY_W-1:0] ONE  = DELAY_W'(1);

  logic [DELAY_W-1:0] delay_cnt;
  logic               snd;
  logic               rest;

  assign rest = (half_period == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delay_cnt <= '0;
      snd       <= 1'b0;
    end else if (!run || rest) begin
      delay_cnt <= '0;
      snd       <= 1'b0;
    end else if (delay_cnt == half_period - ONE) begin
      delay_cnt <= '0;
      snd       <= ~snd;
    end else begin
      delay_cnt <= delay_cnt + ONE;
    end
  end

  assign sample = (run && !rest) ? (snd ? AMP : NAMP) : '0;

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Lobby music / one-shot SFX scheduler sharing one tone datapath
// and the Audio_Controller FIFO, fixed priority with preemption.
module audio_sfx_scheduler
  import audio_sfx_pkg::*;
#(
  parameter int BEAT_CYCLES = 2500000,
  parameter int ADDR_W      = 10,
  parameter int DELAY_W     = 19,
  parameter int AMPLITUDE   = 100000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  lobby_en,
  input  logic [2:0]            sfx_req,
  audio_sfx_scheduler_if.master aud,
  output logic [1:0]            active_track,
  output logic                  busy,
  output logic                  sfx_done
);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);

  state_t              state, nstate;
  logic [1:0]          track, ntrack, hi, launch_trk;
  logic [ADDR_W-1:0]   index, nindex;
  logic [DELAY_W-1:0]  half_period;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [2:0]          pending, clr;
  logic                has_pend, launch, beat_end, last_beat;
  logic signed [31:0]  sample;

  assign has_pend  = |pending;
  assign beat_end  = (beat_cnt == BEAT_LAST);
  assign last_beat = (index == ADDR_W'(trk_len(track) - 1));

  // overlapping requests are normal, so this must be priority
  always_comb begin
    hi = TRK_LOBBY;
    priority case (1'b1)
      pending[0]: hi = TRK_OVER;
      pending[1]: hi = TRK_MISS;
      pending[2]: hi = TRK_HIT;
      default:    hi = TRK_LOBBY;
    endcase
  end

  always_comb begin
    nstate     = state;
    ntrack     = track;
    nindex     = index;
    launch     = 1'b0;
    launch_trk = TRK_LOBBY;
    clr        = 3'b000;
    sfx_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (has_pend) begin
          launch     = 1'b1;
          launch_trk = hi;
        end else if (lobby_en) begin
          launch = 1'b1;
        end
      end
      FETCH, PLAY: begin
        if (has_pend && (track == TRK_LOBBY || hi < track)) begin
          launch     = 1'b1;
          launch_trk = hi;
        end else if (track == TRK_LOBBY && !lobby_en) begin
          nstate = IDLE;
        end else if (state == FETCH) begin
          nstate = PLAY;
        end else if (beat_end) begin
          nstate = FETCH;
          if (!last_beat) begin
            nindex = index + ADDR_W'(1);
          end else if (track == TRK_LOBBY) begin
            nindex = '0;
          end else begin
            sfx_done = 1'b1;
            if (has_pend) begin
              launch     = 1'b1;
              launch_trk = hi;
            end else if (lobby_en) begin
              launch = 1'b1;
            end else begin
              nstate = IDLE;
            end
          end
        end
      end
      default: nstate = IDLE;
    endcase
    if (launch) begin
      nstate = FETCH;
      ntrack = launch_trk;
      nindex = '0;
      clr    = trk_mask(launch_trk);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      track       <= TRK_LOBBY;
      index       <= '0;
      half_period <= '0;
      beat_cnt    <= '0;
      pending     <= 3'b000;
    end else begin
      state    <= nstate;
      track    <= ntrack;
      index    <= nindex;
      pending  <= (pending & ~clr) | sfx_req;
      beat_cnt <= (state == PLAY) ? beat_cnt + BEAT_W'(1) : '0;
      if (state == FETCH)
        half_period <= aud.rom_q;
    end
  end

  square_tone_gen #(
    .DELAY_W   (DELAY_W),
    .AMPLITUDE (AMPLITUDE)
  ) u_tone (
    .clk         (CLOCK_50),
    .rst         (reset),
    .half_period (half_period),
    .run         (state == PLAY),
    .sample      (sample)
  );

  assign aud.rom_addr = ADDR_W'(trk_base(track)) + index;
  assign aud.write_audio_out = aud.audio_out_allowed && (state == PLAY);
  assign aud.left_channel_audio_out  = sample;
  assign aud.right_channel_audio_out = sample;
  assign active_track = track;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Randomized bench for audio_sfx_scheduler against a beat-level
// reference model of tracks, priorities and tone shape.
module tb_audio_sfx_scheduler;

  localparam int BEAT = 8;
  localparam int AMP  = 100000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lobby_en = 1'b0;
  logic [2:0] sfx_req = 3'b000;
  logic [1:0] active_track;
  logic       busy;
  logic       sfx_done;

  logic [18:0] rom [1024];

  int n_vec = 0;
  int n_err = 0;

  int tbase [4] = '{0, 64, 128, 192};
  int tlen  [4] = '{4, 3, 2, 2};

  bit       m_busy, m_fetch;
  int       m_trk, m_idx, m_p, m_hp;
  bit [2:0] m_pend;

  audio_sfx_scheduler_if #(.ADDR_W(10), .DELAY_W(19)) aif ();

  audio_sfx_scheduler #(.BEAT_CYCLES(BEAT)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .lobby_en     (lobby_en),
    .sfx_req      (sfx_req),
    .aud          (aif),
    .active_track (active_track),
    .busy         (busy),
    .sfx_done     (sfx_done)
  );

  always #5 clk = ~clk;

  assign aif.rom_q = rom[aif.rom_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_fetch = 0;
    m_trk   = 0;
    m_idx   = 0;
    m_p     = 0;
    m_hp    = 0;
    m_pend  = 3'b000;
  endtask

  task automatic launch(input int t);
    m_busy  = 1;
    m_fetch = 1;
    m_trk   = t;
    m_idx   = 0;
    if (t != 0) m_pend[t-1] = 1'b0;
  endtask

  task automatic tick(input logic [2:0] req, input bit len, input bit alw);
    int hi;
    bit play, done, e_busy;
    int e_trk, e_addr;
    logic [31:0] smp;
    @(negedge clk);
    sfx_req = req;
    lobby_en = len;
    aif.audio_out_allowed = alw;
    #1;
    e_busy = m_busy;
    e_trk  = m_trk;
    e_addr = tbase[m_trk] + m_idx;
    play   = m_busy && !m_fetch;
    smp    = '0;
    if (play && m_hp != 0)
      smp = (((m_p / m_hp) % 2) == 1) ? AMP : -AMP;
    hi = 0;
    for (int b = 2; b >= 0; b--)
      if (m_pend[b]) hi = b + 1;
    done = 0;
    if (!m_busy) begin
      if (hi != 0) launch(hi);
      else if (len) launch(0);
    end else if (hi != 0 && (m_trk == 0 || hi < m_trk)) begin
      launch(hi);
    end else if (m_trk == 0 && !len) begin
      m_busy = 0;
    end else if (m_fetch) begin
      m_fetch = 0;
      m_p     = 0;
      m_hp    = int'(rom[tbase[m_trk] + m_idx]);
    end else if (m_p < BEAT - 1) begin
      m_p++;
    end else if (m_idx < tlen[m_trk] - 1) begin
      m_idx++;
      m_fetch = 1;
    end else if (m_trk == 0) begin
      m_idx   = 0;
      m_fetch = 1;
    end else begin
      done = 1;
      if (hi != 0) launch(hi);
      else if (len) launch(0);
      else m_busy = 0;
    end
    m_pend |= req;
    chk("busy", busy, e_busy);
    if (e_busy) begin
      chk("track", active_track, e_trk);
      chk("addr", aif.rom_addr, e_addr);
    end
    chk("write", aif.write_audio_out, play && alw);
    chk("left", aif.left_channel_audio_out, smp);
    chk("right", aif.right_channel_audio_out, smp);
    chk("done", sfx_done, done);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_write"}, aif.write_audio_out, 0);
    chk({tag, "_left"}, aif.left_channel_audio_out, 0);
    chk({tag, "_right"}, aif.right_channel_audio_out, 0);
    chk({tag, "_track"}, active_track, 0);
    chk({tag, "_done"}, sfx_done, 0);
    chk({tag, "_addr"}, aif.rom_addr, 0);
  endtask

  initial begin
    bit len_r;
    logic [2:0] rq;
    aif.audio_out_allowed = 1'b1;
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 4) == 0) ? 19'd0 : 19'($urandom_range(1, 6));
    rom[0] = 19'd3;
    rom[1] = 19'd3;
    rom[2] = 19'd0;
    rom[3] = 19'd3;
    model_reset();

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    // lobby looping, then hit, then game-over preempting hit
    repeat (40) tick(3'b000, 1, 1);
    tick(3'b100, 1, 1);
    repeat (30) tick(3'b000, 1, 1);
    tick(3'b100, 1, 1);
    repeat (6) tick(3'b000, 1, 1);
    tick(3'b001, 1, 1);
    repeat (40) tick(3'b000, 1, 1);

    // miss and hit together from idle
    repeat (5) tick(3'b000, 0, 1);
    tick(3'b110, 0, 1);
    repeat (50) tick(3'b000, 0, 1);

    // FIFO full: no writes, sequencing continues
    repeat (25) tick(3'b000, 1, 0);

    len_r = 1;
    for (int c = 0; c < 3000; c++) begin
      rq = 3'b000;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 49) == 0) rq[b] = 1'b1;
      if ($urandom_range(0, 99) == 0) len_r = !len_r;
      tick(rq, len_r, $urandom_range(0, 3) != 0);
    end

    // async reset mid-play with a request still pending
    repeat (15) tick(3'b000, 1, 1);
    tick(3'b001, 1, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sfx_req = 3'b000;
    lobby_en = 1'b0;
    #1;
    check_reset_outputs("arst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (40) tick(3'b000, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
